// File: rtl/id_stage_pipe.sv
// RISC-V decode stage: register file with write-through bypass, load-use hazard
// detection, and the ID/EX pipeline register with bubble/flush/illegal handling.
module id_stage_pipe #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int CTRL_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [31:0]       instr_d,
    input  logic              valid_d,
    input  logic [CTRL_W-1:0] ctrl_d,
    input  logic [XLEN-1:0]   imm_d,
    input  logic [XLEN-1:0]   pc_d,
    input  logic              use_rs1_d,
    input  logic              use_rs2_d,
    input  logic              load_d,
    input  logic              we_w,
    input  logic [4:0]        rd_w,
    input  logic [XLEN-1:0]   result_w,
    input  logic              flush_e,
    output logic              stall_d,
    output logic              valid_e,
    output logic              load_e,
    output logic              illegal_e,
    output logic [CTRL_W-1:0] ctrl_e,
    output logic [XLEN-1:0]   rd1_e,
    output logic [XLEN-1:0]   rd2_e,
    output logic [XLEN-1:0]   imm_e,
    output logic [XLEN-1:0]   pc_e,
    output logic [4:0]        rs1_e,
    output logic [4:0]        rs2_e,
    output logic [4:0]        rd_e,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int         IDX_W  = (NREG > 16) ? 5 : 4;
    localparam logic [5:0] NREG_L = 6'(NREG);

    function automatic logic in_range(input logic [4:0] idx);
        return ({1'b0, idx} < NREG_L);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic [XLEN-1:0]   rf [NREG];

    logic [4:0]        rs1_p0, rs2_p0, rd_p0;
    logic [XLEN-1:0]   rd1_p0, rd2_p0;
    logic              hazard_p0;
    logic              illegal_p0;
    logic              unused_instr;

    logic              vld_p1;
    logic              load_p1;
    logic              illegal_p1;
    logic [CTRL_W-1:0] ctrl_p1;
    logic [XLEN-1:0]   rd1_p1, rd2_p1, imm_p1, pc_p1;
    logic [4:0]        rs1_p1, rs2_p1, rd_p1;
    logic [CNT_W-1:0]  cnt_p1;

    assign rs1_p0       = instr_d[19:15];
    assign rs2_p0       = instr_d[24:20];
    assign rd_p0        = instr_d[11:7];
    assign unused_instr = ^{instr_d[31:25], instr_d[14:12], instr_d[6:0]};

    // Register file: not reset; x0 and out-of-range destinations are never written
    always_ff @(posedge CLK) begin
        if (we_w && (rd_w != 5'd0) && in_range(rd_w))
            rf[rd_w[IDX_W-1:0]] <= result_w;
    end

    always_comb begin
        rd1_p0 = '0;
        if ((rs1_p0 != 5'd0) && in_range(rs1_p0)) begin
            if (we_w && (rd_w == rs1_p0))
                rd1_p0 = result_w;
            else
                rd1_p0 = rf[rs1_p0[IDX_W-1:0]];
        end
    end

    always_comb begin
        rd2_p0 = '0;
        if ((rs2_p0 != 5'd0) && in_range(rs2_p0)) begin
            if (we_w && (rd_w == rs2_p0))
                rd2_p0 = result_w;
            else
                rd2_p0 = rf[rs2_p0[IDX_W-1:0]];
        end
    end

    // Load-use hazard: a writeback of the same register does not clear it
    assign hazard_p0 = valid_d & vld_p1 & load_p1 & (rd_p1 != 5'd0) &
                       ((use_rs1_d & (rs1_p0 == rd_p1)) |
                        (use_rs2_d & (rs2_p0 == rd_p1)));

    assign illegal_p0 = (use_rs1_d & ~in_range(rs1_p0)) |
                        (use_rs2_d & ~in_range(rs2_p0)) |
                        ~in_range(rd_p0);

    assign stall_d = hazard_p0 & ~flush_e;

    // ID/EX register: flush beats hazard beats empty decode slot
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            vld_p1     <= 1'b0;
            load_p1    <= 1'b0;
            illegal_p1 <= 1'b0;
            ctrl_p1    <= '0;
            rd1_p1     <= '0;
            rd2_p1     <= '0;
            imm_p1     <= '0;
            pc_p1      <= '0;
            rs1_p1     <= '0;
            rs2_p1     <= '0;
            rd_p1      <= '0;
        end else if (flush_e || hazard_p0 || !valid_d) begin
            vld_p1     <= 1'b0;
            load_p1    <= 1'b0;
            illegal_p1 <= 1'b0;
            ctrl_p1    <= '0;
            rd1_p1     <= '0;
            rd2_p1     <= '0;
            imm_p1     <= '0;
            pc_p1      <= '0;
            rs1_p1     <= '0;
            rs2_p1     <= '0;
            rd_p1      <= '0;
        end else begin
            vld_p1     <= 1'b1;
            illegal_p1 <= illegal_p0;
            load_p1    <= illegal_p0 ? 1'b0 : load_d;
            ctrl_p1    <= illegal_p0 ? '0 : ctrl_d;
            rd_p1      <= illegal_p0 ? 5'd0 : rd_p0;
            rd1_p1     <= rd1_p0;
            rd2_p1     <= rd2_p0;
            imm_p1     <= imm_d;
            pc_p1      <= pc_d;
            rs1_p1     <= rs1_p0;
            rs2_p1     <= rs2_p0;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            cnt_p1 <= '0;
        else if (stall_d)
            cnt_p1 <= sat_inc(cnt_p1);
    end

    assign valid_e   = vld_p1;
    assign load_e    = load_p1;
    assign illegal_e = illegal_p1;
    assign ctrl_e    = ctrl_p1;
    assign rd1_e     = rd1_p1;
    assign rd2_e     = rd2_p1;
    assign imm_e     = imm_p1;
    assign pc_e      = pc_p1;
    assign rs1_e     = rs1_p1;
    assign rs2_e     = rs2_p1;
    assign rd_e      = rd_p1;
    assign stall_cnt = cnt_p1;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe: one default instance and one RV32E instance
// with a 4-bit stall counter, both driven by the same decode/writeback stimulus.
module tb_id_stage_pipe;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b1;
    logic [31:0] instr_d = '0;
    logic        valid_d = 1'b0;
    logic [15:0] ctrl_d = '0;
    logic [31:0] imm_d = '0;
    logic [31:0] pc_d = '0;
    logic        use_rs1_d = 1'b0;
    logic        use_rs2_d = 1'b0;
    logic        load_d = 1'b0;
    logic        we_w = 1'b0;
    logic [4:0]  rd_w = '0;
    logic [31:0] result_w = '0;
    logic        flush_e = 1'b0;

    logic        a_stall_d, a_valid_e, a_load_e, a_illegal_e;
    logic [15:0] a_ctrl_e;
    logic [31:0] a_rd1_e, a_rd2_e, a_imm_e, a_pc_e;
    logic [4:0]  a_rs1_e, a_rs2_e, a_rd_e;
    logic [15:0] a_stall_cnt;

    logic        b_stall_d, b_valid_e, b_load_e, b_illegal_e;
    logic [15:0] b_ctrl_e;
    logic [31:0] b_rd1_e, b_rd2_e, b_imm_e, b_pc_e;
    logic [4:0]  b_rs1_e, b_rs2_e, b_rd_e;
    logic [3:0]  b_stall_cnt;

    int tests = 0;
    int fails = 0;

    id_stage_pipe u_a (
        .CLK(CLK), .RST_N(RST_N), .instr_d(instr_d), .valid_d(valid_d), .ctrl_d(ctrl_d),
        .imm_d(imm_d), .pc_d(pc_d), .use_rs1_d(use_rs1_d), .use_rs2_d(use_rs2_d),
        .load_d(load_d), .we_w(we_w), .rd_w(rd_w), .result_w(result_w), .flush_e(flush_e),
        .stall_d(a_stall_d), .valid_e(a_valid_e), .load_e(a_load_e), .illegal_e(a_illegal_e),
        .ctrl_e(a_ctrl_e), .rd1_e(a_rd1_e), .rd2_e(a_rd2_e), .imm_e(a_imm_e), .pc_e(a_pc_e),
        .rs1_e(a_rs1_e), .rs2_e(a_rs2_e), .rd_e(a_rd_e), .stall_cnt(a_stall_cnt)
    );

    id_stage_pipe #(.XLEN(32), .NREG(16), .CTRL_W(16), .CNT_W(4)) u_b (
        .CLK(CLK), .RST_N(RST_N), .instr_d(instr_d), .valid_d(valid_d), .ctrl_d(ctrl_d),
        .imm_d(imm_d), .pc_d(pc_d), .use_rs1_d(use_rs1_d), .use_rs2_d(use_rs2_d),
        .load_d(load_d), .we_w(we_w), .rd_w(rd_w), .result_w(result_w), .flush_e(flush_e),
        .stall_d(b_stall_d), .valid_e(b_valid_e), .load_e(b_load_e), .illegal_e(b_illegal_e),
        .ctrl_e(b_ctrl_e), .rd1_e(b_rd1_e), .rd2_e(b_rd2_e), .imm_e(b_imm_e), .pc_e(b_pc_e),
        .rs1_e(b_rs1_e), .rs2_e(b_rs2_e), .rd_e(b_rd_e), .stall_cnt(b_stall_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_instr(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
        instr_d = {7'd0, rs2, rs1, 3'd0, rd, 7'h33};
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Asynchronous reset with no clock edge
        #2 RST_N = 1'b0;
        #1;
        chk("rst_a_valid", a_valid_e, 0);
        chk("rst_a_pc", a_pc_e, 0);
        chk("rst_a_rd1", a_rd1_e, 0);
        chk("rst_a_ctrl", a_ctrl_e, 0);
        chk("rst_a_cnt", a_stall_cnt, 0);
        chk("rst_b_valid", b_valid_e, 0);
        chk("rst_b_cnt", b_stall_cnt, 0);
        step();
        RST_N = 1'b1;

        // Bypass: write x5 while decoding rs1=5; first load after reset
        we_w = 1'b1; rd_w = 5'd5; result_w = 32'hDEADBEEF;
        valid_d = 1'b1; set_instr(5'd5, 5'd0, 5'd1); use_rs1_d = 1'b1; use_rs2_d = 1'b0;
        ctrl_d = 16'hA5A5; imm_d = 32'h10; pc_d = 32'h100;
        step();
        chk("byp_a_rd1", a_rd1_e, 32'hDEADBEEF);
        chk("byp_b_rd1", b_rd1_e, 32'hDEADBEEF);
        chk("byp_a_valid", a_valid_e, 1);
        chk("byp_a_ctrl", a_ctrl_e, 16'hA5A5);
        chk("byp_a_imm", a_imm_e, 32'h10);
        chk("byp_a_pc", a_pc_e, 32'h100);
        chk("byp_a_rd", a_rd_e, 1);
        chk("byp_a_rs1", a_rs1_e, 5);
        chk("byp_a_illegal", a_illegal_e, 0);

        // Stored read of x5 through rs2
        we_w = 1'b0;
        set_instr(5'd0, 5'd5, 5'd2); use_rs1_d = 1'b0; use_rs2_d = 1'b1;
        step();
        chk("rf_a_rd2", a_rd2_e, 32'hDEADBEEF);
        chk("rf_b_rd2", b_rd2_e, 32'hDEADBEEF);
        chk("rf_a_rd1_x0", a_rd1_e, 0);
        chk("rf_a_rs2", a_rs2_e, 5);

        // x0 ignores writes, both bypassed and stored
        we_w = 1'b1; rd_w = 5'd0; result_w = 32'h1234;
        set_instr(5'd0, 5'd0, 5'd3); use_rs1_d = 1'b1; use_rs2_d = 1'b0;
        step();
        chk("x0_byp_a", a_rd1_e, 0);
        rd_w = 5'd7; result_w = 32'h77;
        step();
        chk("x0_rf_a", a_rd1_e, 0);
        chk("x0_rf_b", b_rd1_e, 0);

        // Load-use hazard on rs2 with a simultaneous writeback of the same register
        we_w = 1'b0; load_d = 1'b1; ctrl_d = 16'h0001;
        set_instr(5'd5, 5'd0, 5'd7); use_rs1_d = 1'b1; use_rs2_d = 1'b0;
        step();
        chk("ld_a_load", a_load_e, 1);
        chk("ld_a_rd", a_rd_e, 7);
        load_d = 1'b0; ctrl_d = 16'h00C3; pc_d = 32'h200;
        set_instr(5'd0, 5'd7, 5'd9); use_rs1_d = 1'b0; use_rs2_d = 1'b1;
        we_w = 1'b1; rd_w = 5'd7; result_w = 32'h99;
        #1;
        chk("hz_a_stall", a_stall_d, 1);
        chk("hz_b_stall", b_stall_d, 1);
        step();
        we_w = 1'b0;
        chk("hz_a_bub_valid", a_valid_e, 0);
        chk("hz_a_bub_ctrl", a_ctrl_e, 0);
        chk("hz_a_bub_rd", a_rd_e, 0);
        chk("hz_a_bub_pc", a_pc_e, 0);
        chk("hz_a_cnt", a_stall_cnt, 1);
        chk("hz_b_cnt", b_stall_cnt, 1);
        #1;
        chk("hz_a_stall_clr", a_stall_d, 0);
        step();
        chk("hz_a_adv_valid", a_valid_e, 1);
        chk("hz_a_adv_rd2", a_rd2_e, 32'h99);
        chk("hz_b_adv_rd2", b_rd2_e, 32'h99);
        chk("hz_a_adv_rd", a_rd_e, 9);
        chk("hz_a_adv_pc", a_pc_e, 32'h200);
        chk("hz_a_adv_ctrl", a_ctrl_e, 16'h00C3);
        chk("hz_a_adv_cnt", a_stall_cnt, 1);

        // Same hazard under flush: no stall, bubble, counter unchanged
        load_d = 1'b1; set_instr(5'd0, 5'd0, 5'd7); use_rs1_d = 1'b0; use_rs2_d = 1'b0;
        step();
        load_d = 1'b0; set_instr(5'd0, 5'd7, 5'd9); use_rs2_d = 1'b1; flush_e = 1'b1;
        #1;
        chk("fl_a_stall", a_stall_d, 0);
        chk("fl_b_stall", b_stall_d, 0);
        step();
        flush_e = 1'b0;
        chk("fl_a_valid", a_valid_e, 0);
        chk("fl_a_ctrl", a_ctrl_e, 0);
        chk("fl_a_cnt", a_stall_cnt, 1);
        chk("fl_b_cnt", b_stall_cnt, 1);

        // Empty decode slot yields a bubble; write x4 meanwhile
        valid_d = 1'b0; pc_d = 32'h300; set_instr(5'd1, 5'd1, 5'd1); use_rs2_d = 1'b0;
        we_w = 1'b1; rd_w = 5'd4; result_w = 32'h44;
        step();
        we_w = 1'b0;
        chk("nv_a_valid", a_valid_e, 0);
        chk("nv_a_pc", a_pc_e, 0);

        // rd=20: illegal on the 16-entry instance, ordinary on the 32-entry one
        valid_d = 1'b1; set_instr(5'd1, 5'd0, 5'd20); use_rs1_d = 1'b1; use_rs2_d = 1'b0;
        ctrl_d = 16'hFFFF; load_d = 1'b1; pc_d = 32'h400;
        step();
        chk("il_b_illegal", b_illegal_e, 1);
        chk("il_b_ctrl", b_ctrl_e, 0);
        chk("il_b_valid", b_valid_e, 1);
        chk("il_b_rd", b_rd_e, 0);
        chk("il_b_load", b_load_e, 0);
        chk("il_b_pc", b_pc_e, 32'h400);
        chk("il_a_illegal", a_illegal_e, 0);
        chk("il_a_ctrl", a_ctrl_e, 16'hFFFF);
        chk("il_a_rd", a_rd_e, 20);

        // Writeback to x20 must not alias x4 on the 16-entry instance
        load_d = 1'b0; ctrl_d = 16'h0011; set_instr(5'd4, 5'd20, 5'd2);
        we_w = 1'b1; rd_w = 5'd20; result_w = 32'h2020;
        step();
        chk("w20_byp_b_rd1", b_rd1_e, 32'h44);
        chk("w20_byp_a_rd1", a_rd1_e, 32'h44);
        chk("w20_byp_a_rd2", a_rd2_e, 32'h2020);
        chk("w20_b_illegal", b_illegal_e, 0);
        we_w = 1'b0;
        step();
        chk("w20_rf_b_rd1", b_rd1_e, 32'h44);
        chk("w20_rf_a_rd2", a_rd2_e, 32'h2020);

        // Twenty load/use pairs: the 4-bit counter saturates at 15
        for (int i = 0; i < 20; i++) begin
            load_d = 1'b1; set_instr(5'd0, 5'd0, 5'd7); use_rs1_d = 1'b0; use_rs2_d = 1'b0;
            step();
            load_d = 1'b0; set_instr(5'd0, 5'd7, 5'd9); use_rs2_d = 1'b1;
            #1;
            chk("sat_b_stall", b_stall_d, 1);
            step();
        end
        chk("sat_b_cnt", b_stall_cnt, 15);
        chk("sat_a_cnt", a_stall_cnt, 21);

        // Reset asserted mid-stall clears everything without a clock edge
        load_d = 1'b1; set_instr(5'd0, 5'd0, 5'd7); use_rs2_d = 1'b0; pc_d = 32'h500;
        step();
        load_d = 1'b0; set_instr(5'd0, 5'd7, 5'd9); use_rs2_d = 1'b1;
        #1;
        chk("mr_a_stall_pre", a_stall_d, 1);
        RST_N = 1'b0;
        #1;
        chk("mr_a_stall", a_stall_d, 0);
        chk("mr_a_valid", a_valid_e, 0);
        chk("mr_a_load", a_load_e, 0);
        chk("mr_a_pc", a_pc_e, 0);
        chk("mr_a_rd", a_rd_e, 0);
        chk("mr_a_cnt", a_stall_cnt, 0);
        chk("mr_b_cnt", b_stall_cnt, 0);
        chk("mr_b_stall", b_stall_d, 0);
        step();
        RST_N = 1'b1;
        valid_d = 1'b0;
        step();
        chk("post_a_valid", a_valid_e, 0);
        chk("post_a_cnt", a_stall_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/id_stage_pipe.md
ID_STAGE_PIPE -- requirements
Module: id_stage_pipe

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning datapath and register width.
REQ-002 The block SHALL have parameter NREG, default 32, meaning architectural register count; legal values 16 (RV32E) or 32.
REQ-003 The block SHALL have parameter CTRL_W, default 16, meaning width of the pre-decoded control bundle.
REQ-004 The block SHALL have parameter CNT_W, default 16, meaning stall counter width.
REQ-005 The block SHALL have ports:
  CLK  in  1  clock, rising edge; one clock only
  RST_N  in  1  reset, asynchronous, active-low
  instr_d  in  32  decode-stage instruction; rs1=[19:15], rs2=[24:20], rd=[11:7]
  valid_d  in  1  instr_d holds a live instruction
  ctrl_d  in  CTRL_W  control bundle from the control unit
  imm_d  in  XLEN  extended immediate
  pc_d  in  XLEN  instruction PC
  use_rs1_d, use_rs2_d  in  1 each  instruction reads rs1/rs2
  load_d  in  1  instruction is a load
  we_w  in  1  writeback enable
  rd_w  in  5  writeback register
  result_w  in  XLEN  writeback data
  flush_e  in  1  kill decode instruction (taken branch/jump)
  stall_d  out  1  hold fetch and IF/ID register
  valid_e, load_e, illegal_e  out  1 each  ID/EX flags
  ctrl_e  out  CTRL_W  registered control
  rd1_e, rd2_e, imm_e, pc_e  out  XLEN each  registered operands
  rs1_e, rs2_e, rd_e  out  5 each  registered register indices
  stall_cnt  out  CNT_W  stall cycle count

Function
REQ-006 The register file SHALL hold NREG entries of XLEN bits; entry 0 SHALL read 0 and SHALL ignore writes.
REQ-007 A write SHALL occur at rising CLK when we_w=1, rd_w!=0 and rd_w<NREG; rd_w>=NREG SHALL be ignored.
REQ-008 Reads SHALL be combinational with write-through bypass: if we_w=1, rd_w==rs, rs!=0, read data SHALL equal result_w in the same cycle.
REQ-009 Hazard SHALL be: valid_d & valid_e & load_e & rd_e!=0 & ((use_rs1_d & rs1==rd_e) | (use_rs2_d & rs2==rd_e)).
REQ-010 stall_d SHALL equal hazard & !flush_e, combinationally.
REQ-011 A bubble SHALL set valid_e, load_e, illegal_e, ctrl_e, rd_e, rs1_e, rs2_e to 0; data fields SHALL be 0.
REQ-012 At each rising CLK, priority order: flush_e=1 -> bubble; else hazard -> bubble; else valid_d=0 -> bubble; else load ID/EX.
REQ-013 Load ID/EX SHALL capture ctrl_d, imm_d, pc_d, load_d, rs1/rs2/rd fields, bypassed read data, valid_e=1; latency one cycle.
REQ-014 If any used rs field, or rd field, is >=NREG, loaded entry SHALL have illegal_e=1, ctrl_e=0, load_e=0, valid_e=1, rd_e=0.
REQ-015 stall_cnt SHALL increment by 1 each cycle stall_d=1 and saturate at 2^CNT_W-1 (no wrap).
REQ-016 Simultaneous hazard and writeback of the same register SHALL still stall; bypass SHALL not clear the hazard.
REQ-017 Register file contents SHALL not be reset; software-visible values after reset are undefined except entry 0.

Reset
REQ-018 RST_N=0 SHALL immediately, without CLK, force all ID/EX outputs to 0 and stall_cnt to 0.
REQ-019 Assertion mid-stall SHALL drop stall_d to 0 (valid_e=0) and discard the in-flight instruction.
REQ-020 First ID/EX load SHALL occur at the first rising CLK after RST_N rises.

Verification
REQ-021 Write x5=0xDEADBEEF via we_w, same cycle decode rs1=5 -> next cycle rd1_e=0xDEADBEEF.
REQ-022 Load to x7 in E, decode reads rs2=7 with use_rs2_d=1 -> stall_d=1 one cycle, bubble in E, stall_cnt=1, then instruction advances.
REQ-023 Same hazard with flush_e=1 -> stall_d=0, bubble in E, stall_cnt unchanged.
REQ-024 NREG=16, decode rd=20 -> illegal_e=1, ctrl_e=0, valid_e=1; we_w to x20 leaves registers unchanged.
REQ-025 CNT_W=4, hold hazard 20 cycles -> stall_cnt saturates at 15.
REQ-026 Write x0=0x1234, read rs1=0 -> rd1_e=0; RST_N pulse mid-stall -> all outputs 0 asynchronously.
